// File: rtl/lut_and_i8_i8_i8.sv
//------------------------------------------------------------------------------
// Module  : lut_and_i8_i8_i8
// Brief   : 8-bit bitwise AND (y = a & b) built from one 2-input LUT per bit.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lut_and_i8_i8_i8_lut2 #(
    parameter logic [3:0] INIT = 4'b0000
) (
    input  logic I0,
    input  logic I1,
    output logic O
);

    // The truth table is addressed by {I1, I0}, matching FPGA LUT2 semantics.
    assign O = INIT[{I1, I0}];

endmodule

module lut_and_i8_i8_i8 (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);

    localparam logic [3:0] c_AND_INIT = 4'b1000;

    // Clock and reset are only present for a uniform operator interface.
    logic w_unused;
    assign w_unused = clock ^ reset;

    genvar i;
    generate
        for (i = 0; i < 8; i = i + 1) begin : g_bit
            lut_and_i8_i8_i8_lut2 #(
                .INIT (c_AND_INIT)
            ) u_lut (
                .I0 (a[i]),
                .I1 (b[i]),
                .O  (y[i])
            );
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_lut_and_i8_i8_i8.sv
//------------------------------------------------------------------------------
// Module  : tb_lut_and_i8_i8_i8
// Brief   : Directed-vector scoreboard bench for lut_and_i8_i8_i8.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lut_and_i8_i8_i8;

    logic       clock;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;

    logic [7:0] exp_q[$];
    string      name_q[$];
    event       sample_ev;
    int         n_vec;
    int         n_err;
    bit         mon_busy;

    lut_and_i8_i8_i8 dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .y     (y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: the combinational output is "presented" a short settle time
    // after every stimulus change; pop the matching expectation and compare.
    initial begin
        logic [7:0] e;
        string      nm;
        forever begin
            @(sample_ev);
            mon_busy = 1'b1;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL orphan_sample: y=%h with no expected value queued", y);
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (y !== e) begin
                    n_err++;
                    $display("FAIL %s: a=%h b=%h y=%h expected=%h", nm, a, b, y, e);
                end
            end
            mon_busy = 1'b0;
        end
    end

    task automatic drive(input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] ve, input string nm);
        a = va;
        b = vb;
        exp_q.push_back(ve);
        name_q.push_back(nm);
        #2;
        ->sample_ev;
        #0.1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        mon_busy = 1'b0;
        reset    = 1'b1;
        a        = 8'h00;
        b        = 8'h00;

        // Reset held: y must still equal a & b, with no reset value.
        @(posedge clock); #1;
        drive(8'hF0, 8'h3C, 8'h30, "reset_hold_0");
        for (int k = 1; k < 3; k++) begin
            @(posedge clock); #1;
            drive(8'hF0, 8'h3C, 8'h30, $sformatf("reset_hold_%0d", k));
        end
        @(posedge clock); #1;
        reset = 1'b0;
        drive(8'hF0, 8'h3C, 8'h30, "reset_release");

        // First cycle after reset: zero latency.
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        drive(8'd9, 8'd15, 8'd9, "first_after_reset");

        @(posedge clock); #1; drive(8'hFF, 8'hA5, 8'hA5, "a_ones");
        @(posedge clock); #1; drive(8'h3C, 8'hFF, 8'h3C, "b_ones");
        @(posedge clock); #1; drive(8'hAA, 8'h55, 8'h00, "complement");
        @(posedge clock); #1; drive(8'h00, 8'hFF, 8'h00, "a_zero");
        @(posedge clock); #1; drive(8'h5A, 8'h00, 8'h00, "b_zero");
        @(posedge clock); #1; drive(8'h6B, 8'h6B, 8'h6B, "a_eq_b");
        @(posedge clock); #1; drive(8'hC3, 8'h96, 8'h82, "mixed");

        // Mid-cycle change: y must follow before the next rising edge.
        @(posedge clock); #1; drive(8'h0F, 8'hFF, 8'h0F, "midcycle_pre");
        @(negedge clock); #1; drive(8'hF0, 8'hFF, 8'hF0, "midcycle_post");

        // Walking one across each operand.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = 8'h01 << i;
            @(posedge clock); #1;
            drive(w, 8'hFF, w, $sformatf("walk_a_bit%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] w;
            w = 8'h01 << i;
            @(posedge clock); #1;
            drive(8'hFF, w, w, $sformatf("walk_b_bit%0d", i));
        end

        // Mid-run reset pulse must not disturb the result.
        @(posedge clock); #1;
        reset = 1'b1;
        drive(8'h77, 8'hE1, 8'h61, "reset_midrun");
        @(posedge clock); #1;
        reset = 1'b0;
        drive(8'h77, 8'hE1, 8'h61, "reset_midrun_release");

        @(posedge clock); #1;
        if (mon_busy || exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d expected values left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
